// File: rtl/sudoku_grid_reader.sv
// -----------------------------------------------------------------------------
// sudoku_grid_reader
//
// Read-out engine for the Sudoku grid store. A start pulse walks every cell in
// row-major order: each cell is fetched over the store's one-cycle-latency read
// port, captured, and then presented as one beat on a valid/ready stream tagged
// with its row, column and an end-of-dump flag.
//
// Optional feature (compile-time macro SUDOKU_READER_CKSUM_EN):
//   When defined, one extra beat follows the last cell. It carries the XOR of
//   all accepted cell values, with out_cksum=1 and out_last=1. When undefined,
//   the checksum state and register do not exist, out_cksum is tied low and
//   out_last marks the last cell.
//
// Parameters
//   GRID_N    grid side length (2..15)
//   CELL_W    cell value width in bits
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      request a dump; honoured only when idle or done
//   abort      synchronous abort back to idle; beats in flight are dropped
//   rd_en      read strobe to the grid store
//   rd_row     read row address (valid with rd_en)
//   rd_col     read column address (valid with rd_en)
//   rd_data    cell value from the store, valid the cycle after rd_en
//   out_valid  stream beat valid
//   out_ready  stream sink ready
//   out_data   cell value, or checksum on the checksum beat
//   out_row    row of the current beat
//   out_col    column of the current beat
//   out_last   final beat of the dump
//   out_cksum  current beat is the checksum beat
//   busy       dump in progress
//   done       sticky completion flag, cleared by start, abort or reset
// -----------------------------------------------------------------------------
module sudoku_grid_reader #(
    parameter int unsigned GRID_N = 9,
    parameter int unsigned CELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [3:0]        rd_row,
    output logic [3:0]        rd_col,
    input  logic [CELL_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CELL_W-1:0] out_data,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              out_last,
    output logic              out_cksum,
    output logic              busy,
    output logic              done
);

    // Highest legal counter value; counters wrap here and never reach GRID_N.
    localparam logic [3:0] LastIdx = 4'(GRID_N - 1);

`ifdef SUDOKU_READER_CKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent,
        StCksum,
        StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent,
        StDone
    } state_e;
`endif

    state_e state_q, state_d;

    logic [3:0]        row_q, col_q;
    logic [3:0]        row_d, col_d;
    logic [CELL_W-1:0] out_data_q;
    logic [3:0]        out_row_q, out_col_q;
    logic              out_last_q;
    logic              done_q;
    logic              last_cell;

`ifdef SUDOKU_READER_CKSUM_EN
    logic [CELL_W-1:0] cksum_q;
`endif

    // Counters point at the bottom-right cell.
    assign last_cell = (row_q == LastIdx) && (col_q == LastIdx);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic; abort overrides everything
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StFetch;
                    end
                end
                StFetch: state_d = StLoad;
                StLoad:  state_d = StPresent;
                StPresent: begin
                    if (out_ready) begin
                        if (last_cell) begin
`ifdef SUDOKU_READER_CKSUM_EN
                            state_d = StCksum;
`else
                            state_d = StDone;
`endif
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
`ifdef SUDOKU_READER_CKSUM_EN
                StCksum: begin
                    if (out_ready) begin
                        state_d = StDone;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        rd_en     = (state_q == StFetch);
        busy      = (state_q != StIdle) && (state_q != StDone);
`ifdef SUDOKU_READER_CKSUM_EN
        out_valid = (state_q == StPresent) || (state_q == StCksum);
        out_cksum = (state_q == StCksum);
`else
        out_valid = (state_q == StPresent);
        out_cksum = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // Row-major cell counter advance
    // -------------------------------------------------------------------------
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (col_q == LastIdx) begin
            col_d = 4'd0;
            row_d = (row_q == LastIdx) ? 4'd0 : row_q + 4'd1;
        end else begin
            col_d = col_q + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            out_data_q <= '0;
            out_row_q  <= 4'd0;
            out_col_q  <= 4'd0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SUDOKU_READER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            // Sticky while parked in DONE; start, abort and reset all leave it.
            done_q <= (state_d == StDone);
            if (abort) begin
                out_last_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start) begin
                            row_q      <= 4'd0;
                            col_q      <= 4'd0;
                            out_last_q <= 1'b0;
`ifdef SUDOKU_READER_CKSUM_EN
                            cksum_q    <= '0;
`endif
                        end
                    end
                    StLoad: begin
                        out_data_q <= rd_data;
                        out_row_q  <= row_q;
                        out_col_q  <= col_q;
`ifdef SUDOKU_READER_CKSUM_EN
                        out_last_q <= 1'b0;
`else
                        out_last_q <= last_cell;
`endif
                    end
                    StPresent: begin
                        if (out_ready) begin
                            row_q <= row_d;
                            col_q <= col_d;
`ifdef SUDOKU_READER_CKSUM_EN
                            cksum_q <= cksum_q ^ out_data_q;
                            // Checksum beat reuses the held row/col of the last cell.
                            if (last_cell) begin
                                out_data_q <= cksum_q ^ out_data_q;
                                out_last_q <= 1'b1;
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_row   = row_q;
    assign rd_col   = col_q;
    assign out_data = out_data_q;
    assign out_row  = out_row_q;
    assign out_col  = out_col_q;
    assign out_last = out_last_q;
    assign done     = done_q;

endmodule

// File: doc/sudoku_grid_reader.md
# sudoku_grid_reader

Read-out engine for the Sudoku grid store: on a start pulse it walks all 81 cells in row-major order, fetches each cell over the store's one-cycle-latency read port, and transmits it as a valid/ready stream tagged with row, column and end-of-grid. It is the outbound counterpart of the serial cell loader. It feeds the pin-level output mux, so a host can read back the loaded or solved board.

## Interface
- GRID_N, 9, grid side length; legal range 2..15
- CELL_W, 4, cell value width in bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a dump; honoured only in IDLE or DONE
- abort  in  1  synchronous abort; returns to IDLE on the next edge; wins over all other inputs except reset
- rd_en  out  1  read strobe to the grid store
- rd_row  out  4  read row address, valid while rd_en=1
- rd_col  out  4  read column address, valid while rd_en=1
- rd_data  in  CELL_W  cell value, valid in the cycle after rd_en=1
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts the beat
- out_data  out  CELL_W  cell value, or checksum on the checksum beat
- out_row  out  4  row of the current beat
- out_col  out  4  column of the current beat
- out_last  out  1  final beat of the dump
- out_cksum  out  1  current beat is the checksum beat; only with the macro below
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  sticky high from completion until the next start, abort or reset

## Operation
- States are IDLE, FETCH, LOAD, PRESENT, CKSUM and DONE.
- IDLE/DONE + start → FETCH. Row and column counters clear to 0 and the checksum clears to 0. Leaving DONE clears done.
- FETCH: rd_en=1 with rd_row/rd_col set to the counters. Always → LOAD.
- LOAD: rd_data is captured into the out_data register, and out_row/out_col are loaded from the counters. → PRESENT.
- PRESENT: out_valid=1. out_data, out_row, out_col and out_last are held stable until out_valid&&out_ready.
- On acceptance in PRESENT:
  - checksum ^= out_data.
  - If col==GRID_N-1, col wraps to 0 and row increments; otherwise col increments.
  - If the accepted cell was (GRID_N-1, GRID_N-1), the next state is CKSUM when the macro is enabled, otherwise DONE. Else the next state is FETCH.
- out_last=1 only on the final beat of the dump: cell (GRID_N-1, GRID_N-1) without the macro, or the checksum beat with it.
- Entering DONE sets done=1.
- start while busy is ignored.
- abort in any state: next state IDLE, out_valid=0, rd_en=0, done=0. An in-flight beat is dropped, not completed.
- No value range check: rd_data is forwarded unchanged, including 0 (empty cell) and values above 9.
- Counter arithmetic is 4-bit with explicit compare-and-wrap at GRID_N-1. Modulo operators are not used. Counters never reach GRID_N.

## Timing
- Reset values: rd_en=0, rd_row=0, rd_col=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, out_cksum=0, busy=0, done=0. The FSM resets to IDLE.
- start sampled at edge t:
  - rd_en=1 in cycle t+1.
  - out_valid=1 in cycle t+3.
- With out_ready tied high, each cell takes 3 cycles: FETCH, LOAD, PRESENT.
  - A 9×9 dump spans 243 cycles from the first FETCH to done=1.
  - With the checksum enabled it spans 244 cycles.
- Reset mid-dump: all outputs return to reset values immediately (asynchronous); the block restarts in IDLE.

## Configuration
- SUDOKU_READER_CKSUM_EN defined:
  - After the last cell, the CKSUM state presents one extra beat with out_data = XOR of all accepted cell values, out_row=GRID_N-1, out_col=GRID_N-1, out_cksum=1, out_last=1.
  - Acceptance of that beat → DONE.
- SUDOKU_READER_CKSUM_EN undefined:
  - The CKSUM state and the checksum register are absent.
  - out_cksum is tied to 0.
  - out_last is asserted on cell (8,8).

## Test plan
- Store holds value (r+c)%9+1 at each cell; pulse start with out_ready=1. Expect 81 beats in row-major order with matching row, column and data, out_last only on (8,8), and done=1 exactly 243 cycles after the first rd_en.
- Random out_ready backpressure at 30% duty. Expect out_data/row/col held stable across stall cycles and no beat lost or duplicated.
- abort asserted while presenting cell (4,7). Expect out_valid=0 and busy=0 the next cycle, and done=0. A subsequent start restarts at (0,0).
- start pulsed during a dump at cell (2,3). Expect the stream unaffected; after DONE, a new start clears done and dumps again.
- rst_n asserted mid-dump. Expect all outputs at reset values immediately and no rd_en until the next start.
- Macro enabled, all cells = 5 (81 values). Expect an 82nd beat with out_data=5, out_cksum=1 and out_last=1; out_last=0 on cell (8,8).
